// File: rtl/trg_out_ctrl_mc.sv
// Multi-source trigger output controller: edge-qualified trigger acceptance, programmable pulse/check
// width, dead time, busy flag and saturating lost-trigger count. TRG_SRC_TAG_EN builds the source tag register.
module trg_out_ctrl_mc #(
   parameter int N_SRC           = 3,
   parameter int TRG_PULSE_WIDTH = 20,
   parameter int CHK_PULSE_WIDTH = 50,
   parameter int CHK_SHIFT       = 12,
   parameter int DT_W            = 8
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [N_SRC-1:0] trg_src_in,
   input  logic [N_SRC-1:0] trg_mask_in,
   input  logic             trg_enb_in,
   input  logic [DT_W-1:0]  trg_dead_time_in,
   input  logic [15:0]      eff_trg_cnt_in,
   output logic             eff_trg_out,
   output logic             trg_out_N,
   output logic             daq_busy_out,
   output logic [15:0]      lost_trg_cnt_out,
   output logic [N_SRC-1:0] trg_src_out
);

   localparam int PW_MAX = (CHK_PULSE_WIDTH > TRG_PULSE_WIDTH) ? CHK_PULSE_WIDTH : TRG_PULSE_WIDTH;
   localparam int PW_W   = $clog2(PW_MAX + 1);
   localparam logic [15:0] CHK_MASK = 16'((32'd1 << CHK_SHIFT) - 32'd1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_DEAD  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [N_SRC-1:0]  prev_q, prev_d;
   logic [PW_W-1:0]   pw_cnt_q, pw_cnt_d;
   logic [DT_W-1:0]   dt_cnt_q, dt_cnt_d;
   logic [15:0]       lost_q, lost_d;
   logic              eff_q, eff_d;
   logic              trg_n_q, trg_n_d;
   logic              busy_q, busy_d;

   logic [N_SRC-1:0]  qual_s;
   logic              any_qual_s;
   logic              chk_s;
   logic              accept_s;

   // Edge qualification and check-trigger detection
   always_comb begin
      qual_s     = trg_src_in & ~prev_q & trg_mask_in & {N_SRC{trg_enb_in}};
      any_qual_s = |qual_s;
      chk_s      = ((eff_trg_cnt_in & CHK_MASK) == CHK_MASK);
      prev_d     = trg_src_in;
   end

   // Next-state, counters and registered-output values
   always_comb begin
      state_d  = state_q;
      pw_cnt_d = pw_cnt_q;
      dt_cnt_d = dt_cnt_q;
      accept_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (any_qual_s) begin
               accept_s = 1'b1;
               state_d  = ST_PULSE;
               pw_cnt_d = chk_s ? PW_W'(CHK_PULSE_WIDTH) : PW_W'(TRG_PULSE_WIDTH);
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PULSE: begin
            if (pw_cnt_q <= PW_W'(1)) begin
               if (trg_dead_time_in == {DT_W{1'b0}}) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d  = ST_DEAD;
                  dt_cnt_d = trg_dead_time_in;
               end
            end else begin
               pw_cnt_d = pw_cnt_q - PW_W'(1);
            end
         end
         ST_DEAD: begin
            if (dt_cnt_q <= DT_W'(1)) begin
               state_d = ST_IDLE;
            end else begin
               dt_cnt_d = dt_cnt_q - DT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Edges arriving while busy are lost; the count saturates rather than wraps
      if ((state_q != ST_IDLE) && any_qual_s && (lost_q != 16'hFFFF)) begin
         lost_d = lost_q + 16'd1;
      end else begin
         lost_d = lost_q;
      end

      eff_d   = accept_s;
      trg_n_d = (state_d != ST_PULSE);
      busy_d  = (state_d != ST_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q  <= ST_IDLE;
         prev_q   <= {N_SRC{1'b1}};
         pw_cnt_q <= {PW_W{1'b0}};
         dt_cnt_q <= {DT_W{1'b0}};
         lost_q   <= 16'h0000;
         eff_q    <= 1'b0;
         trg_n_q  <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         prev_q   <= prev_d;
         pw_cnt_q <= pw_cnt_d;
         dt_cnt_q <= dt_cnt_d;
         lost_q   <= lost_d;
         eff_q    <= eff_d;
         trg_n_q  <= trg_n_d;
         busy_q   <= busy_d;
      end
   end

   assign eff_trg_out      = eff_q;
   assign trg_out_N        = trg_n_q;
   assign daq_busy_out     = busy_q;
   assign lost_trg_cnt_out = lost_q;

`ifdef TRG_SRC_TAG_EN
   logic [N_SRC-1:0] src_q, src_d;

   // Hold the bitmap of the last accepted trigger
   always_comb begin
      if (accept_s) begin
         src_d = qual_s;
      end else begin
         src_d = src_q;
      end
   end

   // Source tag register
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         src_q <= {N_SRC{1'b0}};
      end else begin
         src_q <= src_d;
      end
   end

   assign trg_src_out = src_q;
`else
   assign trg_src_out = {N_SRC{1'b0}};
`endif

endmodule

// File: tb/tb_trg_out_ctrl_mc.sv
// Directed self-checking bench for trg_out_ctrl_mc (N_SRC=3, widths 20/50, CHK_SHIFT=12).
module tb_trg_out_ctrl_mc;

`ifdef TRG_SRC_TAG_EN
   localparam bit TAG_EN = 1'b1;
`else
   localparam bit TAG_EN = 1'b0;
`endif

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [2:0]  trg_src_in;
   logic [2:0]  trg_mask_in;
   logic        trg_enb_in;
   logic [7:0]  trg_dead_time_in;
   logic [15:0] eff_trg_cnt_in;
   logic        eff_trg_out;
   logic        trg_out_N;
   logic        daq_busy_out;
   logic [15:0] lost_trg_cnt_out;
   logic [2:0]  trg_src_out;

   int n_checks = 0;
   int n_errors = 0;

   trg_out_ctrl_mc #(
      .N_SRC(3), .TRG_PULSE_WIDTH(20), .CHK_PULSE_WIDTH(50), .CHK_SHIFT(12), .DT_W(8)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .trg_src_in(trg_src_in), .trg_mask_in(trg_mask_in),
      .trg_enb_in(trg_enb_in), .trg_dead_time_in(trg_dead_time_in), .eff_trg_cnt_in(eff_trg_cnt_in),
      .eff_trg_out(eff_trg_out), .trg_out_N(trg_out_N), .daq_busy_out(daq_busy_out),
      .lost_trg_cnt_out(lost_trg_cnt_out), .trg_src_out(trg_src_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] exp_tag(input logic [2:0] v);
      return TAG_EN ? v : 3'b000;
   endfunction

   // Count low, busy and strobe cycles from the current cycle until busy drops (bounded)
   task automatic run_pulse(output int lo, output int bz, output int ef);
      lo = 0; bz = 0; ef = 0;
      for (int i = 0; i < 400; i++) begin
         if (!daq_busy_out) break;
         if (!trg_out_N) lo++;
         if (eff_trg_out) ef++;
         bz++;
         tick();
      end
   endtask

   int lo, bz, ef;

   initial begin
      rst_in = 1'b1; trg_src_in = 3'b000; trg_mask_in = 3'b000; trg_enb_in = 1'b0;
      trg_dead_time_in = 8'd0; eff_trg_cnt_in = 16'd0;
      repeat (3) tick();
      check_val("rst_eff", 32'(eff_trg_out), 32'd0);
      check_val("rst_trgn", 32'(trg_out_N), 32'd1);
      check_val("rst_busy", 32'(daq_busy_out), 32'd0);
      check_val("rst_lost", 32'(lost_trg_cnt_out), 32'd0);
      check_val("rst_tag", 32'(trg_src_out), 32'd0);
      rst_in = 1'b0;
      tick();

      // Global enable low: no trigger, nothing lost
      trg_mask_in = 3'b111; trg_src_in = 3'b001;
      tick();
      check_val("dis_eff", 32'(eff_trg_out), 32'd0);
      check_val("dis_trgn", 32'(trg_out_N), 32'd1);
      trg_src_in = 3'b000;
      tick();
      check_val("dis_lost", 32'(lost_trg_cnt_out), 32'd0);

      // Normal trigger, dead time 2
      trg_enb_in = 1'b1; trg_dead_time_in = 8'd2; eff_trg_cnt_in = 16'd1; trg_src_in = 3'b010;
      tick();
      check_val("n_eff", 32'(eff_trg_out), 32'd1);
      check_val("n_trgn", 32'(trg_out_N), 32'd0);
      check_val("n_tag", 32'(trg_src_out), 32'(exp_tag(3'b010)));
      trg_src_in = 3'b000;
      run_pulse(lo, bz, ef);
      check_val("n_low", 32'(lo), 32'd20);
      check_val("n_busy", 32'(bz), 32'd22);
      check_val("n_effcnt", 32'(ef), 32'd1);

      // Check trigger at count 4095, normal at 4096
      eff_trg_cnt_in = 16'd4095; trg_src_in = 3'b001;
      tick();
      check_val("c_eff", 32'(eff_trg_out), 32'd1);
      trg_src_in = 3'b000;
      run_pulse(lo, bz, ef);
      check_val("c_low", 32'(lo), 32'd50);
      check_val("c_busy", 32'(bz), 32'd52);
      eff_trg_cnt_in = 16'd4096; trg_src_in = 3'b001;
      tick();
      trg_src_in = 3'b000;
      run_pulse(lo, bz, ef);
      check_val("c4096_low", 32'(lo), 32'd20);

      // Simultaneous edges, enable dropped mid-pulse
      eff_trg_cnt_in = 16'd7; trg_src_in = 3'b101;
      tick();
      check_val("s_eff", 32'(eff_trg_out), 32'd1);
      check_val("s_tag", 32'(trg_src_out), 32'(exp_tag(3'b101)));
      trg_src_in = 3'b000; trg_enb_in = 1'b0; trg_mask_in = 3'b000;
      run_pulse(lo, bz, ef);
      check_val("s_low", 32'(lo), 32'd20);
      check_val("s_busy", 32'(bz), 32'd22);
      check_val("s_effcnt", 32'(ef), 32'd1);
      trg_enb_in = 1'b1; trg_mask_in = 3'b111;

      // Edges during a pulse are lost; a double edge counts once
      trg_src_in = 3'b001;
      tick();
      trg_src_in = 3'b000;
      repeat (3) tick();
      trg_src_in = 3'b010;
      tick();
      trg_src_in = 3'b000;
      repeat (9) tick();
      trg_src_in = 3'b101;
      tick();
      check_val("l_tag_kept", 32'(trg_src_out), 32'(exp_tag(3'b001)));
      trg_src_in = 3'b000;
      run_pulse(lo, bz, ef);
      check_val("l_effcnt", 32'(ef), 32'd0);
      check_val("l_lost", 32'(lost_trg_cnt_out), 32'd2);

      // Rotate a one-hot source so every cycle carries an edge; saturate the lost count
      trg_dead_time_in = 8'd255; trg_src_in = 3'b001;
      for (int i = 0; i < 66000; i++) begin
         tick();
         trg_src_in = {trg_src_in[1:0], trg_src_in[2]};
      end
      trg_src_in = 3'b000;
      tick();
      run_pulse(lo, bz, ef);
      check_val("sat_idle", 32'(daq_busy_out), 32'd0);
      check_val("sat_lost", 32'(lost_trg_cnt_out), 32'h0000FFFF);

      // Reset at pulse cycle 10
      trg_dead_time_in = 8'd2; trg_src_in = 3'b010;
      tick();
      trg_src_in = 3'b000;
      repeat (9) tick();
      rst_in = 1'b1;
      tick();
      check_val("mr_trgn", 32'(trg_out_N), 32'd1);
      check_val("mr_busy", 32'(daq_busy_out), 32'd0);
      check_val("mr_eff", 32'(eff_trg_out), 32'd0);
      check_val("mr_lost", 32'(lost_trg_cnt_out), 32'd0);
      check_val("mr_tag", 32'(trg_src_out), 32'd0);
      rst_in = 1'b0;
      tick();

      // Dead time 0: back to IDLE straight after PULSE, edge on first IDLE cycle accepted
      trg_dead_time_in = 8'd0; trg_src_in = 3'b001;
      tick();
      check_val("d0_eff", 32'(eff_trg_out), 32'd1);
      trg_src_in = 3'b000;
      run_pulse(lo, bz, ef);
      check_val("d0_low", 32'(lo), 32'd20);
      check_val("d0_busy", 32'(bz), 32'd20);
      trg_src_in = 3'b100;
      tick();
      check_val("d0_next_eff", 32'(eff_trg_out), 32'd1);
      check_val("d0_next_tag", 32'(trg_src_out), 32'(exp_tag(3'b100)));
      trg_src_in = 3'b000;
      run_pulse(lo, bz, ef);
      check_val("d0_next_low", 32'(lo), 32'd20);

      // Masked-off source is ignored
      trg_mask_in = 3'b001; trg_src_in = 3'b100;
      tick();
      check_val("m_eff", 32'(eff_trg_out), 32'd0);
      check_val("m_busy", 32'(daq_busy_out), 32'd0);
      trg_src_in = 3'b000;
      tick();
      check_val("m_lost", 32'(lost_trg_cnt_out), 32'd0);

      // Source held high through reset release gives no trigger
      trg_mask_in = 3'b111; trg_src_in = 3'b001; rst_in = 1'b1;
      repeat (2) tick();
      rst_in = 1'b0;
      tick();
      check_val("h_eff", 32'(eff_trg_out), 32'd0);
      tick();
      check_val("h_busy", 32'(daq_busy_out), 32'd0);
      check_val("h_trgn", 32'(trg_out_N), 32'd1);
      trg_src_in = 3'b000;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
